// File: rtl/kgp_pkg.sv
// Shared encodings for the KGP-RISC pipeline controller.
// This package holds opcodes, ALU codes, FSM states, instruction fields and the control bundle.
package kgp_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000001;
  localparam logic [5:0] OP_LW   = 6'b000010;
  localparam logic [5:0] OP_SW   = 6'b000011;
  localparam logic [5:0] OP_BZ   = 6'b000100;
  localparam logic [5:0] OP_BNZ  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000110;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam int unsigned OPC_LSB = 26;
  localparam int unsigned OPC_W   = 6;
  localparam int unsigned RS_LSB  = 21;
  localparam int unsigned RT_LSB  = 16;
  localparam int unsigned RD_LSB  = 11;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned FN_LSB  = 0;
  localparam int unsigned FN_W    = 4;

  typedef struct packed {
    logic [3:0] alufunc;
    logic       alusrc;
    logic       regdest;
    logic       address;
    logic       branch;
    logic       brcond;
    logic       readdmem;
    logic       writedmem;
    logic       memtoreg;
    logic       regwrite;
  } ctrl_t;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [31:0] ir);
    return ir[OPC_LSB +: OPC_W];
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Pure opcode-to-control decode for the ID stage, plus register-source usage and illegal flag.
module ctrl_decode
  import kgp_pkg::*;
(
  input  logic [31:0] ir,
  output ctrl_t       ctrl,
  output logic        rs_used,
  output logic        rt_used,
  output logic        is_halt,
  output logic        illegal
);

  logic [OPC_W-1:0] opc;
  logic             unused_bits;

  assign opc         = opcode_of(ir);
  assign unused_bits = ^ir[OPC_LSB-1:FN_LSB+FN_W];

  always_comb begin
    ctrl    = '0;
    rs_used = 1'b0;
    rt_used = 1'b0;
    is_halt = 1'b0;
    illegal = 1'b0;
    // An all-zero word is the NOP bubble, even though its opcode field matches R-type.
    if (ir != 32'd0) begin
      unique case (opc)
        OP_R: begin
          ctrl.alufunc  = ir[FN_LSB +: FN_W];
          ctrl.regdest  = 1'b1;
          ctrl.regwrite = 1'b1;
          rs_used       = 1'b1;
          rt_used       = 1'b1;
        end
        OP_ADDI: begin
          ctrl.alufunc  = ALU_ADD;
          ctrl.alusrc   = 1'b1;
          ctrl.regwrite = 1'b1;
          rs_used       = 1'b1;
        end
        OP_LW: begin
          ctrl.alufunc  = ALU_ADD;
          ctrl.alusrc   = 1'b1;
          ctrl.readdmem = 1'b1;
          ctrl.memtoreg = 1'b1;
          ctrl.regwrite = 1'b1;
          rs_used       = 1'b1;
        end
        OP_SW: begin
          ctrl.alufunc   = ALU_ADD;
          ctrl.alusrc    = 1'b1;
          ctrl.writedmem = 1'b1;
          rs_used        = 1'b1;
          rt_used        = 1'b1;
        end
        OP_BZ, OP_BNZ: begin
          ctrl.branch = 1'b1;
          ctrl.brcond = opc[0];
          rs_used     = 1'b1;
        end
        OP_J: begin
          ctrl.branch  = 1'b1;
          ctrl.address = 1'b1;
        end
        OP_HALT: is_halt = 1'b1;
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// KGP-RISC pipeline controller: ID decode plus load-use stall, branch squash and HALT drain.
module pipeline_ctrl
  import kgp_pkg::*;
#(
  parameter int unsigned DRAIN_CYC = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir_id,
  input  logic        br_taken,
  output logic [3:0]  alufunc,
  output logic        alusrc,
  output logic        regdest,
  output logic        address,
  output logic        branch,
  output logic        brcond,
  output logic        readdmem,
  output logic        writedmem,
  output logic        memtoreg,
  output logic        regwrite,
  output logic        ldpc,
  output logic        ldir,
  output logic        flush_ifid,
  output logic        halted,
  output logic        illegal_op
);

  localparam int unsigned CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  ctrl_t             dec_ctrl, out_ctrl;
  logic              rs_used, rt_used, is_halt, dec_illegal;
  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              lu_valid_q;
  logic [REG_W-1:0]  lu_rt_q;
  logic              illegal_q;
  logic              stall;
  logic [REG_W-1:0]  rs, rt;

  ctrl_decode u_decode (
    .ir      (ir_id),
    .ctrl    (dec_ctrl),
    .rs_used (rs_used),
    .rt_used (rt_used),
    .is_halt (is_halt),
    .illegal (dec_illegal)
  );

  assign rs = ir_id[RS_LSB +: REG_W];
  assign rt = ir_id[RT_LSB +: REG_W];

  // r0 is hardwired, so a load targeting it never creates a real dependency.
  assign stall = lu_valid_q && (lu_rt_q != '0) &&
                 ((rs_used && (rs == lu_rt_q)) || (rt_used && (rt == lu_rt_q)));

  always_comb begin
    out_ctrl   = '0;
    ldpc       = 1'b0;
    ldir       = 1'b0;
    flush_ifid = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (br_taken) begin
          ldpc       = 1'b1;
          ldir       = 1'b1;
          flush_ifid = 1'b1;
        end else if (stall) begin
          // Bubble only; holding PC and IF/ID replays the dependent instruction.
        end else if (is_halt) begin
          state_d = ST_DRAIN;
          cnt_d   = CNT_W'(DRAIN_CYC - 1);
        end else begin
          ldpc     = 1'b1;
          ldir     = 1'b1;
          out_ctrl = dec_ctrl;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) state_d = ST_HALTED;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_HALTED: ;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      lu_valid_q <= 1'b0;
      lu_rt_q    <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q != ST_HALTED) begin
        lu_valid_q <= out_ctrl.readdmem;
        lu_rt_q    <= rt;
      end
      // A squashed wrong-path word is not a real instruction and must not raise the flag.
      if (state_q == ST_RUN && !br_taken && dec_illegal) illegal_q <= 1'b1;
    end
  end

  assign alufunc    = out_ctrl.alufunc;
  assign alusrc     = out_ctrl.alusrc;
  assign regdest    = out_ctrl.regdest;
  assign address    = out_ctrl.address;
  assign branch     = out_ctrl.branch;
  assign brcond     = out_ctrl.brcond;
  assign readdmem   = out_ctrl.readdmem;
  assign writedmem  = out_ctrl.writedmem;
  assign memtoreg   = out_ctrl.memtoreg;
  assign regwrite   = out_ctrl.regwrite;
  assign halted     = (state_q == ST_HALTED);
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized bench for pipeline_ctrl against a behavioural model of the sequencing rules.
module tb_pipeline_ctrl;

  localparam int DRAIN_CYC = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ir_id = 32'd0;
  logic        br_taken = 1'b0;
  logic [3:0]  alufunc;
  logic        alusrc, regdest, address, branch, brcond;
  logic        readdmem, writedmem, memtoreg, regwrite;
  logic        ldpc, ldir, flush_ifid, halted, illegal_op;

  int n_chk = 0;
  int n_err = 0;

  // Model state: destination of the last issued load (0 = none), edges left in drain (-1 = not
  // draining), terminal halt, sticky illegal.
  logic [4:0] load_dest = 5'd0;
  int         drain_left = -1;
  bit         m_halted = 1'b0;
  bit         m_illegal = 1'b0;

  pipeline_ctrl #(.DRAIN_CYC(DRAIN_CYC)) dut (
    .clk        (clk),
    .reset      (reset),
    .ir_id      (ir_id),
    .br_taken   (br_taken),
    .alufunc    (alufunc),
    .alusrc     (alusrc),
    .regdest    (regdest),
    .address    (address),
    .branch     (branch),
    .brcond     (brcond),
    .readdmem   (readdmem),
    .writedmem  (writedmem),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .ldpc       (ldpc),
    .ldir       (ldir),
    .flush_ifid (flush_ifid),
    .halted     (halted),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference decode, straight from the opcode table.
  // Bundle order: alufunc, alusrc, regdest, address, branch, brcond, rd, wr, m2r, rw.
  function automatic logic [12:0] ref_dec(input logic [31:0] ir, output bit ru, output bit tu,
                                          output bit ill, output bit hlt);
    logic [3:0] af;
    bit src, dst, adr, brn, bc, rdm, wrm, m2r, rw;
    af = 4'd0; {src, dst, adr, brn, bc, rdm, wrm, m2r, rw} = '0;
    ru = 0; tu = 0; ill = 0; hlt = 0;
    if (ir != 32'd0) begin
      case (ir[31:26])
        6'd0: begin af = ir[3:0]; dst = 1; rw = 1; ru = 1; tu = 1; end
        6'd1: begin src = 1; rw = 1; ru = 1; end
        6'd2: begin src = 1; rdm = 1; m2r = 1; rw = 1; ru = 1; end
        6'd3: begin src = 1; wrm = 1; ru = 1; tu = 1; end
        6'd4: begin brn = 1; ru = 1; end
        6'd5: begin brn = 1; bc = 1; ru = 1; end
        6'd6: begin brn = 1; adr = 1; end
        6'd63: hlt = 1;
        default: ill = 1;
      endcase
    end
    return {af, src, dst, adr, brn, bc, rdm, wrm, m2r, rw};
  endfunction

  // Drive one ID word for one cycle, compare all outputs mid-cycle, then advance the model.
  task automatic step(input logic [31:0] ir, input bit br);
    logic [12:0] d, e_ctrl, got;
    logic [4:0]  nd;
    bit ru, tu, il, hl, hz, running, e_pc, e_ir, e_fl;
    ir_id = ir; br_taken = br;
    d = ref_dec(ir, ru, tu, il, hl);
    e_ctrl = '0; e_pc = 0; e_ir = 0; e_fl = 0; nd = 5'd0; hz = 0;
    running = !m_halted && (drain_left < 0);
    if (running) begin
      hz = (load_dest != 5'd0) &&
           ((ru && ir[25:21] == load_dest) || (tu && ir[20:16] == load_dest));
      if (br) begin
        e_pc = 1; e_ir = 1; e_fl = 1;
      end else if (!hz && !hl) begin
        e_pc = 1; e_ir = 1; e_ctrl = d;
        if (d[3]) nd = ir[20:16];
      end
    end
    @(negedge clk);
    got = {alufunc, alusrc, regdest, address, branch, brcond,
           readdmem, writedmem, memtoreg, regwrite};
    check("ctrl", {19'd0, got}, {19'd0, e_ctrl});
    check("ldpc", {31'd0, ldpc}, {31'd0, e_pc});
    check("ldir", {31'd0, ldir}, {31'd0, e_ir});
    check("flush_ifid", {31'd0, flush_ifid}, {31'd0, e_fl});
    check("halted", {31'd0, halted}, {31'd0, m_halted});
    check("illegal_op", {31'd0, illegal_op}, {31'd0, m_illegal});
    @(posedge clk); #1;
    if (running) begin
      load_dest = nd;
      if (!br && il) m_illegal = 1;
      if (!br && hl) drain_left = DRAIN_CYC;
    end else if (drain_left > 0) begin
      load_dest = 5'd0;
      drain_left--;
      if (drain_left == 0) begin
        drain_left = -1;
        m_halted = 1;
      end
    end
  endtask

  // Asynchronous reset: checked immediately, held two edges, released between edges.
  task automatic do_reset();
    ir_id = 32'd0; br_taken = 0;
    reset = 0;
    #1;
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_illegal", {31'd0, illegal_op}, 32'd0);
    check("rst_ldpc", {31'd0, ldpc}, 32'd1);
    check("rst_ldir", {31'd0, ldir}, 32'd1);
    load_dest = 5'd0; drain_left = -1; m_halted = 0; m_illegal = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rnd_instr();
    int r;
    logic [5:0] op;
    r = $urandom_range(0, 99);
    if (r < 5) return 32'd0;
    if      (r < 35) op = 6'd2;
    else if (r < 50) op = 6'd0;
    else if (r < 62) op = 6'd1;
    else if (r < 72) op = 6'd3;
    else if (r < 80) op = 6'($urandom_range(4, 5));
    else if (r < 85) op = 6'd6;
    else if (r < 88) op = 6'($urandom_range(7, 62));
    else if (r < 90) op = 6'd63;
    else             op = 6'd0;
    return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
            7'd0, 4'($urandom_range(0, 15))};
  endfunction

  initial begin
    int k;
    do_reset();
    step(32'd0, 0);
    // Load-use on rs of an R-type: one stall cycle, then issue.
    step(32'h08050000, 0); step(32'h00A13000, 0); step(32'h00A13000, 0);
    // Load into r0 never stalls.
    step(32'h08000000, 0); step(32'h00013000, 0);
    // ADDI reading r5 stalls; ADDI writing r5 does not.
    step(32'h08050000, 0); step(32'h04A70000, 0); step(32'h04A70000, 0);
    step(32'h08050000, 0); step(32'h04450000, 0);
    // Taken branch squashes, also over a pending load-use hazard.
    step(32'h00A13000, 1);
    step(32'h08050000, 0); step(32'h00A13000, 1);
    // Illegal opcode 0x2A is sticky across NOPs until reset.
    step(32'hA8000000, 0);
    for (int i = 0; i < 10; i++) step(32'd0, 0);
    do_reset();
    // HALT: count edges until halted, bounded.
    step(32'hFC000000, 0);
    k = 1;
    while (halted !== 1'b1 && k < 20) begin
      step(32'hFC000000, 0);
      k++;
    end
    check("halt_latency", k, DRAIN_CYC + 1);
    do_reset();
    // Reset asserted mid-drain returns to RUN without waiting for an edge.
    step(32'hFC000000, 0); step(32'hFC000000, 0);
    do_reset();
    // Randomized run; reset after a halt or occasionally during drain.
    for (int i = 0; i < 800; i++) begin
      if (m_halted || (drain_left > 0 && $urandom_range(0, 3) == 0)) do_reset();
      else step(rnd_instr(), $urandom_range(0, 7) == 0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Pipelined control unit for the KGP-RISC five-stage core. It drives the datapath control interface from the other side: it decodes the IF/ID instruction into ID/EX control bits. It also owns the pipeline-sequencing decisions: load-use stall, taken-branch squash, and HALT drain. Forwarding stays in the datapath. This block only inserts bubbles and gates PC and IF/ID loads.

Parameters:
DRAIN_CYC, 3, cycles after HALT leaves ID before halted asserts (EX, MEM, WB drain).

Ports:
clk  in  1  core clock
reset  in  1  asynchronous reset, active-low (asserted when 0)
ir_id  in  32  IF/ID instruction; opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [3:0]
br_taken  in  1  branch or jump in EX resolved taken this cycle
alufunc  out  4  ALU function for ID/EX
alusrc  out  1  1 = immediate operand
regdest  out  1  1 = rd, 0 = rt
address  out  1  1 = direct jump address, 0 = PC-relative
branch  out  1  branch/jump instruction
brcond  out  1  1 = BNZ, 0 = BZ (ignored for J)
readdmem, writedmem, memtoreg, regwrite  out  1 each  MEM/WB controls
ldpc  out  1  PC load enable
ldir  out  1  IF/ID load enable
flush_ifid  out  1  load NOP into IF/ID
halted  out  1  core stopped
illegal_op  out  1  sticky illegal-opcode flag

Behaviour:
- Decode (combinational from ir_id):
  - 000000 R: alufunc=funct, regdest=1, regwrite=1.
  - 000001 ADDI: alufunc=ADD(0000), alusrc=1, regwrite=1.
  - 000010 LW: ADD, alusrc=1, readdmem=1, memtoreg=1, regwrite=1.
  - 000011 SW: ADD, alusrc=1, writedmem=1.
  - 000100 BZ / 000101 BNZ: branch=1, brcond=opcode[0], address=0.
  - 000110 J: branch=1, address=1.
  - 111111 HALT: all controls 0.
  - ir_id==0: NOP, all controls 0.
  - Any other opcode: all controls 0, illegal_op set on the next edge; cleared only by reset.
- Source use for hazard check:
  - rs is a source for R, ADDI, LW, SW, BZ, BNZ.
  - rt is a source only for R and SW.
- Load tracker (registered): lu_valid<=issued readdmem, lu_rt<=ir_id[20:16] every edge where state≠HALTED. Issued means after bubbling.
- stall = lu_valid && lu_rt≠0 && (used rs==lu_rt || used rt==lu_rt).
- Per-cycle priority, state RUN:
  1. br_taken: ldpc=1, ldir=1, flush_ifid=1, all controls bubbled (0). Squashes two wrong-path instructions; any HALT or stall in ID is ignored.
  2. stall: ldpc=0, ldir=0, flush_ifid=0, controls bubbled. Exactly 1 cycle, because the bubble clears lu_valid.
  3. HALT in ID: controls 0, ldpc=0, ldir=0, go to DRAIN, cnt<=DRAIN_CYC-1.
  4. Otherwise: ldpc=1, ldir=1, decoded controls.
- FSM: RUN, DRAIN, HALTED.
  - DRAIN: ldpc=ldir=0, controls 0, cnt decrements; at cnt==0 go to HALTED.
  - HALTED: terminal until reset; halted=1, everything else 0.
  - br_taken cannot occur in DRAIN (no older control instruction remains); ignored there.
- Reset (async, reset==0): state=RUN, lu_valid=0, lu_rt=0, cnt=0, illegal_op=0, halted=0. Outputs follow RUN decode of ir_id; the datapath resets IF/ID to 0, which decodes as NOP, so ldpc=ldir=1. Reset mid-DRAIN or in HALTED returns to RUN immediately.
- All outputs except halted and illegal_op are combinational from state and inputs. Zero-latency decode.

Decomposition:
- Package kgp_pkg holds:
  - opcode constants (OP_R, OP_ADDI, OP_LW, OP_SW, OP_BZ, OP_BNZ, OP_J, OP_HALT)
  - ALU function codes (ALU_ADD…)
  - FSM state encoding
  - instruction field bit positions
- Sub-module ctrl_decode: pure opcode-to-control decode plus rs_used/rt_used/illegal outputs.
- pipeline_ctrl holds the FSM, load tracker, drain counter and priority logic.

Test Plan:
- Reset held 0 for 2 cycles with ir_id=0, release → halted=0, illegal_op=0, ldpc=1, ldir=1, all controls 0.
- LW r5 (0x08050000) then ADD r6,r5,r1 (rs=5) in ID next cycle → that cycle stall: ldpc=0, ldir=0, regwrite=0. Following cycle: regwrite=1, regdest=1, ldpc=1.
- LW r0 then ADD using r0 → no stall (rt=0 exempt).
- LW r5 then ADDI r7,r5 → stall; LW r5 then ADDI r5,r2 (rt=5 is dest only) → no stall.
- ADD in ID with br_taken=1 → flush_ifid=1, ldpc=1, regwrite=0. Same with a LW-use hazard present → flush wins, ldpc=1.
- HALT (0xFC000000) in ID → ldpc=0 at once; halted=1 exactly DRAIN_CYC+1=4 edges later. Assert reset=0 in DRAIN → halted=0 and state RUN asynchronously.
- Opcode 0x2A in ID → all controls 0, illegal_op=1 next edge, still 1 after 10 NOPs, 0 after reset.
